// File: rtl/sp_ram_arbiter_pkg.sv
// Shared types and helpers for the single-port RAM arbiter.
package sp_ram_arb_pkg;

  localparam int STALL_CNT_W = 4;

  // Which port owns the RAM response that arrives in the next cycle.
  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_INSTR = 2'd1,
    OWN_DATA  = 2'd2
  } owner_e;

  // Saturating increment of the instruction-port starvation counter.
  function automatic logic [STALL_CNT_W-1:0] stall_inc(
    input logic [STALL_CNT_W-1:0] cnt,
    input logic [STALL_CNT_W-1:0] limit
  );
    logic [STALL_CNT_W-1:0] res;
    if (cnt >= limit) begin
      res = limit;
    end else begin
      res = cnt + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    end
    return res;
  endfunction

endpackage

// File: rtl/sp_ram_arbiter_if.sv
// Bus bundle between the core's fetch/data ports, the arbiter and the RAM macro.
// slave = arbiter view, master = environment view (core ports + RAM macro).
interface sp_ram_arbiter_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  localparam int BE_W = DATA_WIDTH / 8;

  logic                  instr_req_i;
  logic [ADDR_WIDTH-1:0] instr_addr_i;
  logic                  instr_gnt_o;
  logic                  instr_rvalid_o;
  logic [DATA_WIDTH-1:0] instr_rdata_o;

  logic                  data_req_i;
  logic [ADDR_WIDTH-1:0] data_addr_i;
  logic                  data_we_i;
  logic [BE_W-1:0]       data_be_i;
  logic [DATA_WIDTH-1:0] data_wdata_i;
  logic                  data_gnt_o;
  logic                  data_rvalid_o;
  logic [DATA_WIDTH-1:0] data_rdata_o;

  logic                  ram_en_o;
  logic [ADDR_WIDTH-1:0] ram_addr_o;
  logic                  ram_we_o;
  logic [BE_W-1:0]       ram_be_o;
  logic [DATA_WIDTH-1:0] ram_wdata_o;
  logic [DATA_WIDTH-1:0] ram_rdata_i;

  modport slave (
    input  instr_req_i, instr_addr_i,
    output instr_gnt_o, instr_rvalid_o, instr_rdata_o,
    input  data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
    output data_gnt_o, data_rvalid_o, data_rdata_o,
    output ram_en_o, ram_addr_o, ram_we_o, ram_be_o, ram_wdata_o,
    input  ram_rdata_i
  );

  modport master (
    output instr_req_i, instr_addr_i,
    input  instr_gnt_o, instr_rvalid_o, instr_rdata_o,
    output data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
    input  data_gnt_o, data_rvalid_o, data_rdata_o,
    input  ram_en_o, ram_addr_o, ram_we_o, ram_be_o, ram_wdata_o,
    output ram_rdata_i
  );

endinterface

// File: rtl/sp_ram_arbiter_prio.sv
// Fixed-priority grant (data first) with a starvation counter that forces
// an instruction grant after MAX_STALL consecutive lost cycles.
module sp_ram_arb_prio
  import sp_ram_arb_pkg::*;
#(
  parameter int MAX_STALL = 4
) (
  input  logic clk,
  input  logic rst_i,
  input  logic instr_req_i,
  input  logic data_req_i,
  output logic instr_gnt_o,
  output logic data_gnt_o
);

  localparam logic [STALL_CNT_W-1:0] MAX_CNT = STALL_CNT_W'(MAX_STALL);

  logic [STALL_CNT_W-1:0] stall_cnt_q;
  logic [STALL_CNT_W-1:0] stall_cnt_d;

  // Grant decision from this cycle's requests; nothing is granted in reset.
  always_comb begin
    instr_gnt_o = 1'b0;
    data_gnt_o  = 1'b0;
    if (rst_i) begin
      instr_gnt_o = 1'b0;
      data_gnt_o  = 1'b0;
    end else if (instr_req_i && data_req_i) begin
      if (stall_cnt_q == MAX_CNT) begin
        instr_gnt_o = 1'b1;
      end else begin
        data_gnt_o = 1'b1;
      end
    end else if (instr_req_i) begin
      instr_gnt_o = 1'b1;
    end else if (data_req_i) begin
      data_gnt_o = 1'b1;
    end else begin
      instr_gnt_o = 1'b0;
      data_gnt_o  = 1'b0;
    end
  end

  // Count consecutive cycles the fetch port asked but lost; clear otherwise.
  always_comb begin
    stall_cnt_d = {STALL_CNT_W{1'b0}};
    if (instr_req_i && !instr_gnt_o) begin
      stall_cnt_d = stall_inc(stall_cnt_q, MAX_CNT);
    end else begin
      stall_cnt_d = {STALL_CNT_W{1'b0}};
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      stall_cnt_q <= {STALL_CNT_W{1'b0}};
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: rtl/sp_ram_arbiter.sv
// Shares one single-port SRAM between the fetch port and the load/store
// port, and steers the 1-cycle-latency read response back to its owner.
module sp_ram_arbiter
  import sp_ram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_STALL  = 4
) (
  input logic        clk,
  input logic        rst_i,
  sp_ram_arbiter_if.slave bus
);

  localparam int BE_W = DATA_WIDTH / 8;

  logic   instr_gnt;
  logic   data_gnt;
  owner_e owner_q;
  owner_e owner_d;

  sp_ram_arb_prio #(
    .MAX_STALL (MAX_STALL)
  ) u_prio (
    .clk         (clk),
    .rst_i       (rst_i),
    .instr_req_i (bus.instr_req_i),
    .data_req_i  (bus.data_req_i),
    .instr_gnt_o (instr_gnt),
    .data_gnt_o  (data_gnt)
  );

  assign bus.instr_gnt_o = instr_gnt;
  assign bus.data_gnt_o  = data_gnt;
  assign bus.ram_en_o    = instr_gnt | data_gnt;

  // Response owner for next cycle is whichever port got the RAM now.
  always_comb begin
    owner_d = OWN_NONE;
    if (instr_gnt) begin
      owner_d = OWN_INSTR;
    end else if (data_gnt) begin
      owner_d = OWN_DATA;
    end else begin
      owner_d = OWN_NONE;
    end
  end

  // Owner register; a reset edge drops any response in flight.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      owner_q <= OWN_NONE;
    end else begin
      owner_q <= owner_d;
    end
  end

  // Read data is fanned out unqualified; rvalid says who it belongs to.
  assign bus.instr_rvalid_o = (owner_q == OWN_INSTR);
  assign bus.data_rvalid_o  = (owner_q == OWN_DATA);
  assign bus.instr_rdata_o  = bus.ram_rdata_i;
  assign bus.data_rdata_o   = bus.ram_rdata_i;

  // RAM command mux: fetches are full-word reads, idle drives all zeros.
  always_comb begin
    bus.ram_addr_o  = {ADDR_WIDTH{1'b0}};
    bus.ram_we_o    = 1'b0;
    bus.ram_be_o    = {BE_W{1'b0}};
    bus.ram_wdata_o = {DATA_WIDTH{1'b0}};
    if (instr_gnt) begin
      bus.ram_addr_o = bus.instr_addr_i;
      bus.ram_we_o   = 1'b0;
      bus.ram_be_o   = {BE_W{1'b1}};
    end else if (data_gnt) begin
      bus.ram_addr_o  = bus.data_addr_i;
      bus.ram_we_o    = bus.data_we_i;
      bus.ram_be_o    = bus.data_be_i;
      bus.ram_wdata_o = bus.data_wdata_i;
    end else begin
      bus.ram_we_o = 1'b0;
    end
  end

endmodule
